// File: rtl/sdram_arbiter_if.sv
// ---------------------------------------------------------------------------
// sdram_arbiter_if -- Wishbone bus bundle used on every arbiter port.
//
// Data is named by direction so the same bundle serves both sides:
//   dat_w : master -> slave (write data)
//   dat_r : slave  -> master (read data)
//
// Modports:
//   master : drives cyc/stb/we/adr/dat_w/sel, samples ack/dat_r
//   slave  : samples cyc/stb/we/adr/dat_w/sel, drives ack/dat_r
// ---------------------------------------------------------------------------
interface sdram_arbiter_if #(
    parameter int AWIDTH = 25,
    parameter int DWIDTH = 32
);
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [AWIDTH-1:0]     adr;
    logic [DWIDTH-1:0]     dat_w;
    logic [DWIDTH-1:0]     dat_r;
    logic [DWIDTH/8-1:0]   sel;
    logic                  ack;

    modport master (output cyc, stb, we, adr, dat_w, sel, input ack, dat_r);
    modport slave  (input cyc, stb, we, adr, dat_w, sel, output ack, dat_r);
endinterface

// File: rtl/sdram_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_arbiter -- two-master Wishbone arbiter in front of the SDRAM port.
//
// Master 0 is the line cache, master 1 a secondary requester (video/DMA).
// Grants are round-robin and held for the whole Wishbone cycle (until the
// owner drops cyc), so cache bursts are never split.  A per-grant stall
// watchdog kicks a master that waits too long for ack, and two saturating
// counters record how often each master was granted.
//
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : asynchronous reset, active low
//   m0, m1   : slave-side bus ports facing the two masters
//   ram      : master-side bus port facing the SDRAM controller
//   owner    : one-hot current owner (bit0 = m0, bit1 = m1, 00 = none)
//   timeout  : sticky watchdog flag
//   grants0/1: saturating grant counters
//   clr_i    : synchronous clear of timeout and both counters
// ---------------------------------------------------------------------------
module sdram_arbiter #(
    parameter int AWIDTH   = 25,
    parameter int DWIDTH   = 32,
    parameter int TIMEOUT  = 1024,
    parameter int CNTWIDTH = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    sdram_arbiter_if.slave      m0,
    sdram_arbiter_if.slave      m1,
    sdram_arbiter_if.master     ram,
    output logic [1:0]          owner,
    output logic                timeout,
    output logic [CNTWIDTH-1:0] grants0,
    output logic [CNTWIDTH-1:0] grants1,
    input  logic                clr_i
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_OWN0    = 2'd1;
    localparam logic [1:0] S_OWN1    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    // Watchdog counts 0..TIMEOUT-1; TIMEOUT >= 2 keeps WDW >= 1.
    localparam int             WDW     = $clog2(TIMEOUT);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    // Request side of one master, bundled so the owner mux is one line.
    typedef struct packed {
        logic                cyc;
        logic                stb;
        logic                we;
        logic [AWIDTH-1:0]   adr;
        logic [DWIDTH-1:0]   dat;
        logic [DWIDTH/8-1:0] sel;
    } wb_req_t;

    logic [1:0]     state;
    logic [1:0]     state_nxt;
    logic           last;       // most recent grantee: 0 = m0, 1 = m1
    logic [WDW-1:0] wd;

    wb_req_t req0, req1, req_sel;
    logic    own0, own1, owning;
    logic    fire;
    logic    gnt0, gnt1;

    assign req0 = {m0.cyc, m0.stb, m0.we, m0.adr, m0.dat_w, m0.sel};
    assign req1 = {m1.cyc, m1.stb, m1.we, m1.adr, m1.dat_w, m1.sel};

    assign own0   = (state == S_OWN0);
    assign own1   = (state == S_OWN1);
    assign owning = own0 | own1;
    assign owner  = {own1, own0};

    // Watchdog fires on the cycle the count sits at TIMEOUT-1: that cycle
    // the bus is withdrawn and the owner is moved to RELEASE.
    assign fire = owning && (wd == WD_LAST);

    // Contention goes to whoever was not granted last.
    assign gnt0 = (state == S_IDLE) && m0.cyc && (!m1.cyc || last);
    assign gnt1 = (state == S_IDLE) && m1.cyc && (!m0.cyc || !last);

    // Outside ownership everything toward the SDRAM is held at zero.
    always_comb begin
        req_sel = '0;
        if (own0)      req_sel = req0;
        else if (own1) req_sel = req1;
    end

    assign ram.cyc   = req_sel.cyc & ~fire;
    assign ram.stb   = req_sel.stb & ~fire;
    assign ram.we    = req_sel.we;
    assign ram.adr   = req_sel.adr;
    assign ram.dat_w = req_sel.dat;
    assign ram.sel   = req_sel.sel;

    // Read data goes to both masters; only the owner ever sees ack.
    assign m0.dat_r = ram.dat_r;
    assign m1.dat_r = ram.dat_r;
    assign m0.ack   = own0 & ram.ack & ~fire;
    assign m1.ack   = own1 & ram.ack & ~fire;

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (gnt0)      state_nxt = S_OWN0;
                else if (gnt1) state_nxt = S_OWN1;
            end
            S_OWN0:  if (fire || !m0.cyc) state_nxt = S_RELEASE;
            S_OWN1:  if (fire || !m1.cyc) state_nxt = S_RELEASE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
            last  <= 1'b1;
            wd    <= '0;
        end else begin
            state <= state_nxt;
            if (gnt0)      last <= 1'b0;
            else if (gnt1) last <= 1'b1;
            if (gnt0 || gnt1)
                wd <= '0;
            else if (owning && !fire)
                wd <= ram.ack ? '0 : wd + 1'b1;
        end
    end

    // Statistics; clr_i wins over a same-cycle grant or watchdog event.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            timeout <= 1'b0;
            grants0 <= '0;
            grants1 <= '0;
        end else if (clr_i) begin
            timeout <= 1'b0;
            grants0 <= '0;
            grants1 <= '0;
        end else begin
            if (fire)                  timeout <= 1'b1;
            if (gnt0 && grants0 != '1) grants0 <= grants0 + 1'b1;
            if (gnt1 && grants1 != '1) grants1 <= grants1 + 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_arbiter -- self-checking bench for sdram_arbiter.
//
// Two bus-master behaviours and an SDRAM ack source are driven from TB
// variables.  A transaction-level model (owner index, dead-cycle count,
// last grantee, stall count, counters) predicts every DUT output each cycle.
// Directed scenarios come first, then a long randomized run.
// ---------------------------------------------------------------------------
module tb_sdram_arbiter;
    localparam int AW   = 25;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;
    localparam int TO   = 8;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    logic clr_i = 1'b0;
    always #5 clk_i = ~clk_i;

    sdram_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) m0_if ();
    sdram_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) m1_if ();
    sdram_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) ram_if ();

    logic [1:0]    owner;
    logic          timeout;
    logic [CW-1:0] grants0, grants1;

    sdram_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(TO), .CNTWIDTH(CW)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .m0      (m0_if),
        .m1      (m1_if),
        .ram     (ram_if),
        .owner   (owner),
        .timeout (timeout),
        .grants0 (grants0),
        .grants1 (grants1),
        .clr_i   (clr_i)
    );

    // stimulus
    logic          mcyc[2], mstb[2], mwe[2];
    logic [AW-1:0] madr[2];
    logic [DW-1:0] mdat[2];
    logic [SW-1:0] msel[2];
    logic          ram_ack;
    logic [DW-1:0] ram_dat;

    assign m0_if.cyc   = mcyc[0];
    assign m0_if.stb   = mstb[0];
    assign m0_if.we    = mwe[0];
    assign m0_if.adr   = madr[0];
    assign m0_if.dat_w = mdat[0];
    assign m0_if.sel   = msel[0];
    assign m1_if.cyc   = mcyc[1];
    assign m1_if.stb   = mstb[1];
    assign m1_if.we    = mwe[1];
    assign m1_if.adr   = madr[1];
    assign m1_if.dat_w = mdat[1];
    assign m1_if.sel   = msel[1];
    assign ram_if.ack   = ram_ack;
    assign ram_if.dat_r = ram_dat;

    // master behaviour
    bit act[2];
    int beats[2], pat[2];
    int p_start, stb_gap, ack_mode, ack_pct, a3;

    // reference model
    int own, rel, last, stall;
    int cnt[2];
    bit to_flag;
    bit fire;
    bit e_ack[2];

    // observations
    logic [1:0] o_owner;
    logic       o_cyc, o_to;
    int         n_ack[2];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        own = -1; rel = 0; last = 1; stall = 0;
        cnt[0] = 0; cnt[1] = 0; to_flag = 0;
    endtask

    task automatic new_beat(input int i);
        madr[i] = AW'($urandom);
        mdat[i] = $urandom;
        msel[i] = SW'($urandom);
    endtask

    task automatic req(input int i, input int n, input bit we);
        act[i] = 1; beats[i] = n; pat[i] = -1; mwe[i] = we;
        new_beat(i);
    endtask

    task automatic model_next();
        int w;
        if (own < 0 && rel == 0) begin
            w = -1;
            if (mcyc[0] && mcyc[1]) w = 1 - last;
            else if (mcyc[0])       w = 0;
            else if (mcyc[1])       w = 1;
            if (w >= 0) begin
                own = w; last = w; stall = 0;
                if (cnt[w] < CMAX) cnt[w]++;
            end
        end else if (own < 0) begin
            rel = 0;
        end else if (fire) begin
            to_flag = 1; own = -1; rel = 1;
        end else if (!mcyc[own]) begin
            own = -1; rel = 1;
        end else if (ram_ack) begin
            stall = 0;
        end else begin
            stall++;
        end
        if (clr_i) begin
            to_flag = 0; cnt[0] = 0; cnt[1] = 0;
        end
    endtask

    task automatic master_update();
        for (int i = 0; i < 2; i++) begin
            if (act[i]) begin
                if (e_ack[i]) begin
                    beats[i]--;
                    if (beats[i] == 0) act[i] = 0;
                    else new_beat(i);
                end else if (pat[i] > 0) begin
                    pat[i]--;
                    if (pat[i] == 0) act[i] = 0;
                end
            end else if ($urandom_range(0, 99) < p_start) begin
                act[i]   = 1;
                beats[i] = $urandom_range(1, 4);
                pat[i]   = $urandom_range(3, 25);
                mwe[i]   = 1'($urandom);
                new_beat(i);
            end
        end
    endtask

    // One clock: drive at negedge, check at negedge+1, advance model at posedge.
    task automatic cycle();
        logic [63:0] e_ram;
        for (int i = 0; i < 2; i++) begin
            mcyc[i] = act[i];
            mstb[i] = act[i] && ($urandom_range(0, 99) >= stb_gap);
        end
        ram_dat = $urandom;
        fire  = (own >= 0) && (stall == TO - 1);
        e_ram = '0;
        if (own >= 0)
            e_ram = {mcyc[own] & ~fire, mstb[own] & ~fire, mwe[own], msel[own], madr[own], mdat[own]};
        if (ack_mode == 1) begin
            ram_ack = e_ram[62] && (a3 == 2);
            if (e_ram[62]) a3 = (a3 + 1) % 3;
        end else begin
            ram_ack = e_ram[62] && ($urandom_range(0, 99) < ack_pct);
        end
        e_ack[0] = (own == 0) && ram_ack && !fire;
        e_ack[1] = (own == 1) && ram_ack && !fire;
        #1;
        chk("ram_bus", {ram_if.cyc, ram_if.stb, ram_if.we, ram_if.sel, ram_if.adr, ram_if.dat_w}, e_ram);
        chk("m_ack", {m1_if.ack, m0_if.ack}, {e_ack[1], e_ack[0]});
        chk("m_rdat", {m1_if.dat_r, m0_if.dat_r}, {ram_dat, ram_dat});
        chk("owner", owner, own == 0 ? 2'b01 : own == 1 ? 2'b10 : 2'b00);
        chk("stats", {timeout, grants1, grants0}, {to_flag, CW'(cnt[1]), CW'(cnt[0])});
        o_owner = owner;
        o_cyc   = ram_if.cyc;
        o_to    = timeout;
        n_ack[0] += int'(m0_if.ack);
        n_ack[1] += int'(m1_if.ack);
        @(posedge clk_i);
        model_next();
        master_update();
        @(negedge clk_i);
    endtask

    task automatic run_idle(input string tag, input int max);
        bit done;
        done = 0;
        for (int k = 0; k < max && !done; k++) begin
            cycle();
            done = !act[0] && !act[1] && own < 0 && rel == 0;
        end
        chk({tag, "_done"}, done, 1);
    endtask

    task automatic do_reset();
        rst_i = 0;
        act[0] = 0; act[1] = 0;
        mcyc[0] = 0; mcyc[1] = 0; mstb[0] = 0; mstb[1] = 0;
        ram_ack = 0;
        model_reset();
        @(negedge clk_i);
        rst_i = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int seen1, dead, got, owned;
        for (int i = 0; i < 2; i++) begin
            mcyc[i] = 0; mstb[i] = 0; mwe[i] = 0;
            madr[i] = '0; mdat[i] = '0; msel[i] = '0;
            act[i] = 0; beats[i] = 0; pat[i] = -1; n_ack[i] = 0;
        end
        p_start = 0; stb_gap = 0; ack_mode = 0; ack_pct = 100; a3 = 0;
        ram_dat = '0;
        model_reset();

        // reset holds everything quiet even with a request and an ack present
        mcyc[0] = 1; mstb[0] = 1; ram_ack = 1;
        #12;
        chk("rst_owner", owner, 2'b00);
        chk("rst_stats", {timeout, grants1, grants0}, '0);
        chk("rst_ram", {ram_if.cyc, ram_if.stb, ram_if.we, ram_if.adr}, '0);
        chk("rst_ack", {m1_if.ack, m0_if.ack}, 2'b00);
        mcyc[0] = 0; mstb[0] = 0; ram_ack = 0;
        @(negedge clk_i);
        rst_i = 1;

        // 1: m0 4-beat read, ack every 3rd cycle
        ack_mode = 1; a3 = 0; n_ack[0] = 0; n_ack[1] = 0;
        req(0, 4, 0);
        run_idle("t1", 60);
        chk("t1_acks0", n_ack[0], 4);
        chk("t1_acks1", n_ack[1], 0);
        chk("t1_grants0", grants0, 1);

        // 2: simultaneous requests, loser withdraws; order m0, m1, m0
        do_reset();
        ack_mode = 0; ack_pct = 100;
        for (int r = 0; r < 3; r++) begin
            req(0, 1, 0);
            req(1, 1, 1);
            cycle();
            #1 chk("t2_grant", owner, (r == 1) ? 2'b10 : 2'b01);
            act[(r == 1) ? 0 : 1] = 0;
            run_idle("t2", 20);
        end
        chk("t2_grants0", grants0, 2);
        chk("t2_grants1", grants1, 1);

        // 3: m0 requests during m1's burst; waits, 2 dead cycles after drop
        ack_mode = 1; a3 = 0; n_ack[0] = 0; n_ack[1] = 0;
        req(1, 4, 1);
        cycle(); cycle(); cycle();
        req(0, 1, 0);
        seen1 = 0; dead = 0; got = 0;
        for (int k = 0; k < 80 && got == 0; k++) begin
            cycle();
            if (o_owner == 2'b10) seen1 = 1;
            else if (o_owner == 2'b00 && seen1 != 0) dead++;
            else if (o_owner == 2'b01) got = 1;
        end
        chk("t3_got", got, 1);
        chk("t3_m1_beats", n_ack[1], 4);
        chk("t3_dead", dead, 2);
        run_idle("t3", 40);

        // 4: watchdog on a never-acked m0, pending m1 then granted
        ack_mode = 0; ack_pct = 0;
        req(0, 1, 1);
        cycle();
        req(1, 1, 0);
        owned = 0; got = 0;
        for (int k = 0; k < 40 && got == 0; k++) begin
            cycle();
            if (o_owner == 2'b01 && o_cyc) owned++;
            if (o_owner == 2'b10) got = 1;
        end
        chk("t4_got", got, 1);
        chk("t4_owned", owned, TO - 1);
        chk("t4_flag", o_to, 1);
        ack_pct = 100; act[0] = 0;
        run_idle("t4", 20);
        clr_i = 1;
        cycle();
        clr_i = 0;
        #1 chk("t4_clr", timeout, 0);

        // 5: counter saturation, then clear against a same-cycle grant
        for (int k = 0; k < 20; k++) begin
            req(0, 1, 0);
            run_idle("t5", 10);
        end
        chk("t5_sat", grants0, CMAX);
        req(0, 1, 0);
        clr_i = 1;
        cycle();
        clr_i = 0;
        #1;
        chk("t5_clr_gnt", grants0, 0);
        chk("t5_clr_own", owner, 2'b01);
        run_idle("t5b", 10);

        // 6: async reset in the middle of a write beat
        ack_pct = 0;
        req(0, 4, 1);
        cycle(); cycle(); cycle();
        ram_ack = 1;
        #1;
        chk("t6_pre_cyc", ram_if.cyc, 1);
        chk("t6_pre_we", ram_if.we, 1);
        #1 rst_i = 0;
        #1;
        chk("t6_cyc", ram_if.cyc, 0);
        chk("t6_we", ram_if.we, 0);
        chk("t6_ack", m0_if.ack, 0);
        act[0] = 0; mcyc[0] = 0; mstb[0] = 0; ram_ack = 0;
        @(negedge clk_i);
        rst_i = 1;
        model_reset();
        #1 chk("t6_owner", owner, 2'b00);

        // randomized traffic with slow/dead SDRAM phases and random clears
        p_start = 25; stb_gap = 20; ack_mode = 0;
        for (int k = 0; k < 3000; k++) begin
            if (k % 150 == 0) ack_pct = ((k / 150) % 3 == 1) ? 3 : 60;
            clr_i = ($urandom_range(0, 49) == 0);
            cycle();
        end
        clr_i = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

- Two-master Wishbone arbiter that shares the single SDRAM controller port (rambus) between the line cache and a second bus master, such as a video or DMA engine.
- Grants are round-robin and locked per Wishbone cycle: once a master owns the bus, it keeps it until it drops cyc, so cache fill/flush bursts are never split.
- Sits between the cache's rambus master port and the SDRAM controller's slave port.
- Also provides a per-grant stall watchdog and grant counters for software statistics.

## Interface
Parameters:
- AWIDTH, 25, address width forwarded to the SDRAM port
- DWIDTH, 32, data width
- TIMEOUT, 1024, owned cycles without ack before the watchdog fires (≥2)
- CNTWIDTH, 16, width of each grant counter

Ports:
- clk_i  in  1  single clock; all logic on the rising edge
- rst_i  in  1  asynchronous, active-low reset
- m0  if_wb.slave  —  master 0 (cache rambus); higher initial priority
- m1  if_wb.slave  —  master 1 (secondary requester)
- ram  if_wb.master  —  to the SDRAM controller
- owner  out  2  one-hot current owner: bit0 = m0, bit1 = m1, 00 = idle
- timeout  out  1  sticky watchdog flag
- grants0, grants1  out  CNTWIDTH  saturating grant counters
- clr_i  in  1  synchronous clear of timeout and both counters

## Operation
State machine: S_IDLE, S_OWN0, S_OWN1, S_RELEASE.

S_IDLE:
- m0.cyc only → S_OWN0.
- m1.cyc only → S_OWN1.
- Both → the master that is not `last` wins. `last` is a 1-bit register of the most recent grantee; its reset value is 1, so m0 wins first.
- On a grant: update `last`, increment that master's counter (saturates at all-ones), clear the watchdog counter.

S_OWNn:
- ram.cyc/stb/we/adr/dat_o/sel are driven combinationally from mn.
- mn.ack = ram.ack and mn.dat_o = ram.dat_i.
- ram.dat_i is also fanned out to the other master's dat_o; that master's ack is forced to 0.
- Owner drops cyc → S_RELEASE.
- Ownership is never preempted, whatever the other master requests.

S_RELEASE:
- One dead cycle; all ram outputs are 0.
- Then S_IDLE, which arbitrates again using the updated `last`.

Watchdog:
- In S_OWNn, the counter increments on every cycle without ram.ack and clears on ack.
- When the count reaches TIMEOUT-1: set timeout, force ram.cyc/stb low for one cycle, go to S_RELEASE.
- The stalled master's ack stays 0; recovering that master is software's job.

Other rules:
- In S_IDLE and S_RELEASE, ram.cyc = ram.stb = ram.we = 0, ram.adr = 0, ram.dat_o = 0, ram.sel = 0.
- clr_i has priority over increments in the same cycle.
- clr_i does not affect arbitration state.

## Timing
- Reset (rst_i low, async): state = S_IDLE, last = 1, owner = 00, timeout = 0, grants0 = grants1 = 0, watchdog = 0, all ram outputs 0, m0.ack = m1.ack = 0.
- Arbitration latency: a request seen in S_IDLE at edge N drives ram.cyc in the cycle after edge N. Minimum turnaround from an owner's cyc drop to the next grant is 2 cycles (RELEASE, IDLE).
- Ack/data path is combinational; the arbiter adds zero latency per beat within an owned cycle.
- Back-to-back: if m0 drops and immediately reasserts cyc while m1 is waiting, m1 is granted next (round-robin).
- A master that asserts cyc and then drops it before being granted gets no grant and no counter increment.
- Reset asserted mid-burst: ram.cyc falls asynchronously; no ack is delivered for the in-flight beat.

## Test plan
1. Reset, then m0 issues a 4-beat read burst (cyc held, SDRAM model acks every 3rd cycle) → owner = 01, exactly 4 acks to m0, m1.ack = 0 throughout, grants0 = 1.
2. m0 and m1 assert cyc in the same cycle, three times in a row (each releasing after 1 beat) → grant order m0, m1, m0; grants0 = 2, grants1 = 1.
3. m1 owns with a burst in progress while m0 raises cyc mid-burst → m1 completes all 4 beats uninterrupted; m0 is granted 2 cycles after m1 drops cyc.
4. With TIMEOUT = 8, the SDRAM model never acks m0 → after 7 owned cycles: timeout = 1, ram.cyc low, S_RELEASE; a pending m1 is then granted; clr_i clears timeout.
5. CNTWIDTH = 4, 20 m0-only grants → grants0 stays at 15; clr_i in the same cycle as a grant → grants0 = 0.
6. Assert rst_i low mid-write beat → ram.cyc/we drop the same cycle (asynchronous); after release, state = S_IDLE and owner = 00.
